// File: rtl/lr35902_dbg_pkg.sv
// lr35902_dbg_pkg: debug link frame layout and command opcodes shared by the
// ingress FIFO, the command decoder and the host tool.
package lr35902_dbg_pkg;

   localparam int DBG_FRAME_W  = 9;
   localparam int DBG_STOP_BIT = 8;

   typedef logic [DBG_FRAME_W-1:0] dbg_frame_t;

   typedef enum logic [7:0] {
      DBG_OP_NOP          = 8'h00,
      DBG_OP_HALT         = 8'h01,
      DBG_OP_STEP         = 8'h02,
      DBG_OP_CONTINUE     = 8'h03,
      DBG_OP_PREP_DRVDATA = 8'h04,
      DBG_OP_SET_CONTROL  = 8'h05,
      DBG_OP_SET_DRVDATA  = 8'h06,
      DBG_OP_SET_BRKPT    = 8'h07
   } dbg_op_e;

   function automatic logic dbg_stop_ok(dbg_frame_t f);
      return f[DBG_STOP_BIT];
   endfunction

endpackage

// File: rtl/lr35902_sync_bit.sv
// lr35902_sync_bit: N-stage single-bit synchroniser; flops are deliberately
// not reset so the chain only ever carries the sampled source level.
module lr35902_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk)
      sr <= {sr[STAGES-2:0], d};

   assign q = sr[STAGES-1];

endmodule

// File: rtl/lr35902_dbg_cmd_fifo.sv
// lr35902_dbg_cmd_fifo: UART toggle-handshake frame ingress into a DEPTH-entry
// command FIFO. Macro LR35902_DBG_CMD_ERRCNT_EN builds the saturating err_count.
module lr35902_dbg_cmd_fifo
   import lr35902_dbg_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int DEPTH_LOG2  = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  cpu_clk,
   input  logic                  reset,
   input  dbg_frame_t            rx_frame,
   input  logic                  rx_seq,
   output logic                  rx_ack,
   output dbg_frame_t            cmd_data,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  frame_err,
   input  logic                  err_clr,
   output logic [7:0]            err_count
);

   logic                  seq_s, seen;
   logic                  pending, stop_ok, accept, push, discard, pop;
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   dbg_frame_t            mem [DEPTH];

   lr35902_sync_bit #(.STAGES(SYNC_STAGES)) u_seq_sync (
      .clk (cpu_clk),
      .d   (rx_seq),
      .q   (seq_s)
   );

   // A bad stop bit is consumed even when full: it never needs a slot.
   assign pending   = seq_s != seen;
   assign stop_ok   = dbg_stop_ok(rx_frame);
   assign accept    = pending && (!full || !stop_ok);
   assign push      = accept && stop_ok;
   assign discard   = accept && !stop_ok;
   assign pop       = cmd_valid && cmd_ready;
   assign cmd_valid = count != '0;
   assign full      = count == (DEPTH_LOG2+1)'(DEPTH);
   assign cmd_data  = mem[rd_ptr];

   always_ff @(posedge cpu_clk)
      if (push) mem[wr_ptr] <= rx_frame;

   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         seen      <= seq_s;
         rx_ack    <= seq_s;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         frame_err <= 1'b0;
      end else begin
         if (accept) begin
            seen   <= seq_s;
            rx_ack <= seq_s;
         end
         if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         count     <= (push && !pop) ? count + (DEPTH_LOG2+1)'(1) :
                      (pop && !push) ? count - (DEPTH_LOG2+1)'(1) : count;
         frame_err <= discard | (frame_err & ~err_clr);
      end
   end

`ifdef LR35902_DBG_CMD_ERRCNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge cpu_clk)
      if (reset) err_cnt_q <= '0;
      else if (discard) err_cnt_q <= err_clr ? 8'd1 : (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      else if (err_clr) err_cnt_q <= '0;

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_lr35902_dbg_cmd_fifo.sv
// tb_lr35902_dbg_cmd_fifo: vector table plus hand sequences; popped frames are
// checked against a queue of frames expected from the receiver side.
module tb_lr35902_dbg_cmd_fifo;

`ifdef LR35902_DBG_CMD_ERRCNT_EN
   localparam bit ERRCNT = 1'b1;
`else
   localparam bit ERRCNT = 1'b0;
`endif

   logic       cpu_clk = 1'b0;
   logic       reset = 1'b1;
   logic [8:0] rx_frame = '0;
   logic       rx_seq = 1'b0;
   logic       rx_ack;
   logic [8:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready = 1'b0;
   logic [3:0] count;
   logic       full;
   logic       frame_err;
   logic       err_clr = 1'b0;
   logic [7:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [8:0] sb [$];

   typedef struct {
      logic [8:0] frame;
      logic [3:0] exp_count;
      logic       exp_err;
      logic [7:0] exp_errs;
   } vec_t;
   vec_t vt [6];

   lr35902_dbg_cmd_fifo dut (
      .cpu_clk   (cpu_clk),
      .reset     (reset),
      .rx_frame  (rx_frame),
      .rx_seq    (rx_seq),
      .rx_ack    (rx_ack),
      .cmd_data  (cmd_data),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .count     (count),
      .full      (full),
      .frame_err (frame_err),
      .err_clr   (err_clr),
      .err_count (err_count)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] e(int n);
      return ERRCNT ? 8'(n) : 8'd0;
   endfunction

   // One clock; any pop about to happen is scored at the preceding negedge.
   task automatic tick();
      @(negedge cpu_clk);
      if (!reset && cmd_valid && cmd_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_unexpected: got 0x%0h expected no frame", cmd_data);
         end else check("pop_data", 32'(cmd_data), 32'(sb.pop_front()));
      end
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic send(logic [8:0] f, bit wait_ack);
      int k = 0;
      rx_frame = f;
      rx_seq   = ~rx_seq;
      if (f[8]) sb.push_back(f);
      if (wait_ack) begin
         while (rx_ack !== rx_seq && k < 20) begin
            tick();
            k++;
         end
         if (rx_ack !== rx_seq) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: frame 0x%0h got no ack", f);
         end
      end
   endtask

   task automatic drain();
      int k = 0;
      cmd_ready = 1'b1;
      while (cmd_valid && k < 40) begin
         tick();
         k++;
      end
      cmd_ready = 1'b0;
      check("drain_empty", 32'(count), 32'd0);
      check("drain_sb", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      vt[0] = '{9'h1A5, 4'd1, 1'b0, e(0)};
      vt[1] = '{9'h0FF, 4'd1, 1'b1, e(1)};
      vt[2] = '{9'h1C3, 4'd2, 1'b1, e(1)};
      vt[3] = '{9'h000, 4'd2, 1'b1, e(2)};
      vt[4] = '{9'h100, 4'd3, 1'b1, e(2)};
      vt[5] = '{9'h07E, 4'd3, 1'b1, e(3)};

      repeat (4) tick();
      reset = 1'b0;
      tick();
      check("rst_count", 32'(count), 32'd0);
      check("rst_valid", 32'(cmd_valid), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_errcnt", 32'(err_count), 32'd0);
      check("rst_ack", 32'(rx_ack), 32'(rx_seq));

      // latency of a single frame into an empty FIFO
      send(9'h100, 1'b0);
      tick();
      check("lat_ack_n", 32'(rx_ack == rx_seq), 32'd0);
      tick();
      check("lat_ack_n1", 32'(rx_ack == rx_seq), 32'd0);
      check("lat_valid_n1", 32'(cmd_valid), 32'd0);
      tick();
      check("lat_ack_n2", 32'(rx_ack), 32'(rx_seq));
      check("lat_valid", 32'(cmd_valid), 32'd1);
      check("lat_data", 32'(cmd_data), 32'h100);
      check("lat_count", 32'(count), 32'd1);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      check("pop_count", 32'(count), 32'd0);
      check("pop_valid", 32'(cmd_valid), 32'd0);

      // overflow holds the ack
      for (int i = 1; i <= 8; i++) send(9'h100 + 9'(i), 1'b1);
      check("full_flag", 32'(full), 32'd1);
      check("full_count", 32'(count), 32'd8);
      send(9'h109, 1'b0);
      repeat (4) tick();
      check("full_ack_held", 32'(rx_ack == rx_seq), 32'd0);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      check("full_pop_count", 32'(count), 32'd7);
      check("full_pop_ack_held", 32'(rx_ack == rx_seq), 32'd0);
      tick();
      check("full_late_ack", 32'(rx_ack), 32'(rx_seq));
      check("full_refill", 32'(count), 32'd8);
      drain();

      // stop-bit error handling
      send(9'h055, 1'b1);
      check("err_count_unch", 32'(count), 32'd0);
      check("err_flag", 32'(frame_err), 32'd1);
      check("err_cnt1", 32'(err_count), 32'(e(1)));
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("err_clr_flag", 32'(frame_err), 32'd0);
      check("err_clr_cnt", 32'(err_count), 32'd0);

      for (int i = 0; i < 6; i++) begin
         send(vt[i].frame, 1'b1);
         check($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].exp_count));
         check($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vt[i].exp_err));
         check($sformatf("vec%0d_errcnt", i), 32'(err_count), 32'(vt[i].exp_errs));
      end
      drain();

      // discard on the same edge as err_clr: the set wins
      send(9'h0AA, 1'b0);
      tick();
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("setwin_ack", 32'(rx_ack), 32'(rx_seq));
      check("setwin_flag", 32'(frame_err), 32'd1);
      check("setwin_cnt", 32'(err_count), 32'(e(1)));
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // accept and pop on one edge across pointer wrap
      for (int i = 0; i < 3; i++) send(9'h1D0 + 9'(i), 1'b1);
      for (int i = 0; i < 20; i++) begin
         send(9'h140 + 9'(i), 1'b0);
         tick();
         tick();
         cmd_ready = 1'b1;
         tick();
         cmd_ready = 1'b0;
         check($sformatf("wrap%0d_count", i), 32'(count), 32'd3);
         check($sformatf("wrap%0d_ack", i), 32'(rx_ack), 32'(rx_seq));
      end
      drain();

      // head stays stable while stalled
      send(9'h1E1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         send(9'h1F0 + 9'(i), 1'b0);
         for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("hold%0d_%0d", i, j), 32'(cmd_data), 32'h1E1);
         end
      end
      check("hold_count", 32'(count), 32'd4);
      drain();

      // reset with buffered and in-flight frames
      for (int i = 0; i < 5; i++) send(9'h1A0 + 9'(i), 1'b1);
      rx_frame = 9'h1FF;
      rx_seq   = ~rx_seq;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      check("mrst_count", 32'(count), 32'd0);
      check("mrst_valid", 32'(cmd_valid), 32'd0);
      check("mrst_ack", 32'(rx_ack), 32'(rx_seq));
      repeat (5) tick();
      check("mrst_no_emit", 32'(cmd_valid), 32'd0);
      check("mrst_count_late", 32'(count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
